// File: rtl/fabric_pkg.sv
// Shared fabric definitions: trit codes, PT-5 constants and loader FSM states.
// Pure declarations, no logic, no latency, no flow control.
package fabric_pkg;

    typedef enum logic [1:0] {
        TRIT_ZERO = 2'b00,
        TRIT_POS  = 2'b01,
        TRIT_NEG  = 2'b10,
        TRIT_INV  = 2'b11
    } trit_e;

    localparam logic [7:0] PT5_ZERO_BYTE  = 8'h79;
    localparam int         BYTES_PER_WORD = 3;
    localparam int         TRITS_PER_BYTE = 5;
    localparam int         TDATA_W        = 2 * TRITS_PER_BYTE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } loader_state_e;

    // Base-3 digit of a trit (t + 1); an invalid code counts as a zero trit.
    function automatic logic [1:0] trit_digit(input logic [1:0] code);
        case (trit_e'(code))
            TRIT_POS: trit_digit = 2'd2;
            TRIT_NEG: trit_digit = 2'd0;
            default:  trit_digit = 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/pt5_stream_loader_if.sv
// Valid/ready trit stream: 5 trits per beat plus last marker.
// Zero latency wiring; the slave side owns s_tready.
// Backpressure: a beat transfers only when s_tvalid and s_tready are both high.
interface pt5_stream_loader_if;
    import fabric_pkg::*;

    logic [TDATA_W-1:0] s_tdata;
    logic               s_tvalid;
    logic               s_tlast;
    logic               s_tready;

    modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
    modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);

endinterface

// File: rtl/pt5_packer.sv
// PT-5 encoder: five trits to one byte, sum of (t+1)*3^k, plus an invalid-trit flag.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result with its own handshake.
module pt5_packer
    import fabric_pkg::*;
(
    input  logic [TDATA_W-1:0] trits,
    output logic [7:0]         pack_byte,
    output logic               invalid
);

    // Horner evaluation from the most significant trit down.
    always_comb begin
        pack_byte = '0;
        invalid   = 1'b0;
        for (int k = TRITS_PER_BYTE - 1; k >= 0; k--) begin
            pack_byte = pack_byte * 8'd3 + {6'd0, trit_digit(trits[2*k +: 2])};
            if (trits[2*k +: 2] == TRIT_INV) begin
                invalid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pt5_stream_loader.sv
// Packs a trit stream into 24-bit words and writes them to the weight or input SRAM bank.
// Latency: the beat completing a word is accepted in cycle N, its SRAM write is in cycle N+1.
// Backpressure: s_tready is high only in LOAD; 1 beat/cycle sustained, dropped after the last word.
module pt5_stream_loader
    import fabric_pkg::*;
#(
    parameter int SRAM_AW = 12,
    parameter int SRAM_DW = 24,
    parameter int CNT_W   = 13
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cfg_start,
    input  logic [SRAM_AW-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]   cfg_word_count,
    input  logic               cfg_bank,
    pt5_stream_loader_if.slave s,
    output logic [SRAM_AW-1:0] sram_waddr,
    output logic [SRAM_DW-1:0] sram_wdata,
    output logic               sram_we_weight,
    output logic               sram_we_input,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   words_written,
    output logic               err_trit,
    output logic               err_length
);

    loader_state_e      state_q, state_d;
    logic [SRAM_AW-1:0] addr_q;
    logic [CNT_W-1:0]   cnt_q, words_q;
    logic               bank_q;
    logic [1:0]         slot_q;
    logic [7:0]         byte0_q, byte1_q;
    logic               wr_vld_q;
    logic [SRAM_DW-1:0] wr_dat_q;
    logic               err_trit_q, err_length_q;

    logic [7:0]         beat_byte;
    logic               beat_inv;
    logic               fire;
    logic               word_full;
    logic               count_hit;
    logic [SRAM_DW-1:0] word_dat;

    pt5_packer u_packer (
        .trits     (s.s_tdata),
        .pack_byte (beat_byte),
        .invalid   (beat_inv)
    );

    assign s.s_tready = (state_q == ST_LOAD);
    assign fire       = s.s_tvalid & s.s_tready;
    assign word_full  = (slot_q == 2'd2);
    // The previous word is always written before the next one can complete, so words_q is exact here.
    assign count_hit  = fire & word_full & ((words_q + CNT_W'(1)) == cnt_q);

    // Unfilled slots of a word cut short by tlast carry the encoding of five zero trits.
    always_comb begin
        case (slot_q)
            2'd0:    word_dat = {PT5_ZERO_BYTE, PT5_ZERO_BYTE, beat_byte};
            2'd1:    word_dat = {PT5_ZERO_BYTE, beat_byte, byte0_q};
            default: word_dat = {beat_byte, byte1_q, byte0_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d = (cfg_word_count == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (count_hit) begin
                    state_d = ST_DONE;
                end else if (fire && s.s_tlast) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q       <= '0;
            cnt_q        <= '0;
            words_q      <= '0;
            bank_q       <= 1'b0;
            slot_q       <= 2'd0;
            byte0_q      <= '0;
            byte1_q      <= '0;
            wr_vld_q     <= 1'b0;
            wr_dat_q     <= '0;
            err_trit_q   <= 1'b0;
            err_length_q <= 1'b0;
        end else begin
            wr_vld_q <= 1'b0;
            if (wr_vld_q) begin
                addr_q  <= addr_q + SRAM_AW'(1);
                words_q <= words_q + CNT_W'(1);
            end
            if (state_q == ST_IDLE && cfg_start) begin
                addr_q       <= cfg_base_addr;
                cnt_q        <= cfg_word_count;
                bank_q       <= cfg_bank;
                words_q      <= '0;
                slot_q       <= 2'd0;
                err_trit_q   <= 1'b0;
                err_length_q <= 1'b0;
            end
            if (fire) begin
                if (beat_inv) begin
                    err_trit_q <= 1'b1;
                end
                if (word_full || s.s_tlast) begin
                    wr_vld_q <= 1'b1;
                    wr_dat_q <= word_dat;
                    slot_q   <= 2'd0;
                end else begin
                    if (slot_q == 2'd0) begin
                        byte0_q <= beat_byte;
                    end else begin
                        byte1_q <= beat_byte;
                    end
                    slot_q <= slot_q + 2'd1;
                end
                // Count reached without tlast, or tlast before the count: both are length errors.
                if (count_hit != s.s_tlast) begin
                    err_length_q <= 1'b1;
                end
            end
        end
    end

    assign sram_waddr     = addr_q;
    assign sram_wdata     = wr_dat_q;
    assign sram_we_weight = wr_vld_q & ~bank_q;
    assign sram_we_input  = wr_vld_q & bank_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = (state_q == ST_DONE);
    assign words_written  = words_q;
    assign err_trit       = err_trit_q;
    assign err_length     = err_length_q;

endmodule

// File: tb/tb_pt5_stream_loader.sv
// Bench for pt5_stream_loader: directed loads checked against a queue-based packing model.
module tb_pt5_stream_loader;
    import fabric_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_start;
    logic [11:0] cfg_base_addr;
    logic [12:0] cfg_word_count;
    logic        cfg_bank;
    logic [11:0] sram_waddr;
    logic [23:0] sram_wdata;
    logic        sram_we_weight, sram_we_input;
    logic        busy, done, err_trit, err_length;
    logic [12:0] words_written;

    always #5 clk = ~clk;

    pt5_stream_loader_if s_if ();

    pt5_stream_loader #(.SRAM_AW(12), .SRAM_DW(24), .CNT_W(13)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_start      (cfg_start),
        .cfg_base_addr  (cfg_base_addr),
        .cfg_word_count (cfg_word_count),
        .cfg_bank       (cfg_bank),
        .s              (s_if),
        .sram_waddr     (sram_waddr),
        .sram_wdata     (sram_wdata),
        .sram_we_weight (sram_we_weight),
        .sram_we_input  (sram_we_input),
        .busy           (busy),
        .done           (done),
        .words_written  (words_written),
        .err_trit       (err_trit),
        .err_length     (err_length)
    );

    typedef struct packed {
        logic        bank;
        logic [11:0] addr;
        logic [23:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [9:0] beats[$];
    bit         lasts[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_acc, exp_words;
    bit         exp_et, exp_el;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Byte value = sum over trits of (t+1)*3^k; invalid trits count as zero.
    function automatic logic [7:0] pack_model(input logic [9:0] d);
        int v = 0;
        int w = 1;
        for (int k = 0; k < 5; k++) begin
            case (d[2*k +: 2])
                2'b01:   v += 2 * w;
                2'b10:   v += 0;
                default: v += w;
            endcase
            w *= 3;
        end
        return 8'(v);
    endfunction

    // Walks the beat list the way the stream contract defines a load and lists the writes it implies.
    task automatic build_model(input logic [11:0] base, input int count, input bit bank);
        logic [7:0] bytes[$];
        int  words = 0;
        bit  full;
        exp_q.delete();
        exp_acc = 0;
        exp_et  = 0;
        exp_el  = 0;
        if (count != 0) begin
            for (int i = 0; i < beats.size(); i++) begin
                exp_acc++;
                for (int k = 0; k < 5; k++) begin
                    if (beats[i][2*k +: 2] == 2'b11) exp_et = 1;
                end
                bytes.push_back(pack_model(beats[i]));
                if (bytes.size() == 3 || lasts[i]) begin
                    full = (bytes.size() == 3);
                    while (bytes.size() < 3) bytes.push_back(8'h79);
                    exp_q.push_back('{bank, 12'(base + 12'(words)), {bytes[2], bytes[1], bytes[0]}});
                    words++;
                    bytes.delete();
                    if (full && words == count) begin
                        exp_el = !lasts[i];
                        break;
                    end
                    if (lasts[i]) begin
                        exp_el = 1;
                        break;
                    end
                end
            end
        end
        exp_words = words;
    endtask

    // Every strobe cycle must match the next expected write; strobes nobody expects are errors.
    always @(negedge clk) begin
        if (reset_n && (sram_we_weight || sram_we_input)) begin
            wr_t e;
            check("we_onehot", 32'(sram_we_weight & sram_we_input), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'({sram_we_input, sram_we_weight}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(sram_waddr), 32'(e.addr));
                check("wr_data", 32'(sram_wdata), 32'(e.data));
                check("wr_bank_input", 32'(sram_we_input), 32'(e.bank));
            end
        end
    end

    task automatic run_load(input string tag, input logic [11:0] base, input int count,
                            input bit bank, input bit gaps);
        int i   = 0;
        int cyc = 0;
        bit seen = 0;
        @(negedge clk);
        cfg_base_addr  = base;
        cfg_word_count = 13'(count);
        cfg_bank       = bank;
        cfg_start      = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check({tag, "_done_after_start"}, 32'(done), 32'(count == 0));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (cyc < 300) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (i < beats.size() && (!gaps || $urandom_range(2) != 0)) begin
                s_if.s_tvalid = 1'b1;
                s_if.s_tdata  = beats[i];
                s_if.s_tlast  = lasts[i];
            end else begin
                s_if.s_tvalid = 1'b0;
            end
            if (s_if.s_tvalid && s_if.s_tready) i++;
            @(negedge clk);
            cyc++;
        end
        s_if.s_tvalid = 1'b0;
        s_if.s_tlast  = 1'b0;
        if (!seen) check({tag, "_done_timeout"}, 32'(done), 32'd1);
        check({tag, "_beats_accepted"}, 32'(i), 32'(exp_acc));
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_words"}, 32'(words_written), 32'(exp_words));
        check({tag, "_err_trit"}, 32'(err_trit), 32'(exp_et));
        check({tag, "_err_length"}, 32'(err_length), 32'(exp_el));
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_we"}, 32'({sram_we_weight, sram_we_input}), 32'd0);
        check({tag, "_words"}, 32'(words_written), 32'd0);
        check({tag, "_errs"}, 32'({err_trit, err_length}), 32'd0);
        check({tag, "_tready"}, 32'(s_if.s_tready), 32'd0);
        check({tag, "_waddr"}, 32'(sram_waddr), 32'd0);
        check({tag, "_wdata"}, 32'(sram_wdata), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        cfg_start      = 1'b0;
        cfg_base_addr  = '0;
        cfg_word_count = '0;
        cfg_bank       = 1'b0;
        s_if.s_tdata   = '0;
        s_if.s_tvalid  = 1'b0;
        s_if.s_tlast   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        reset_n = 1'b1;

        check("pack_zero", 32'(pack_model(10'h000)), 32'h79);
        check("pack_pos", 32'(pack_model(10'h155)), 32'hF2);
        check("pack_neg", 32'(pack_model(10'h2AA)), 32'h00);

        // One full word, count and tlast agree.
        beats = '{10'h155, 10'h155, 10'h155};
        lasts = '{0, 0, 1};
        build_model(12'h010, 1, 1'b0);
        check("t1_model_data", 32'(exp_q[0].data), 32'hF2F2F2);
        check("t1_model_addr", 32'(exp_q[0].addr), 32'h010);
        run_load("t1", 12'h010, 1, 1'b0, 1'b0);

        // Short stream: partial word padded and flushed to the input bank.
        beats = '{10'h2AA};
        lasts = '{1};
        build_model(12'h020, 2, 1'b1);
        check("t2_model_data", 32'(exp_q[0].data), 32'h797900);
        check("t2_model_errlen", 32'(exp_el), 32'd1);
        run_load("t2", 12'h020, 2, 1'b1, 1'b0);

        // Invalid trit packs as zero and raises err_trit.
        beats = '{10'h001, 10'h003, 10'h000};
        lasts = '{0, 0, 1};
        build_model(12'h030, 1, 1'b0);
        check("t3_pack_plus1", 32'(pack_model(10'h001)), 32'h7A);
        check("t3_pack_inv", 32'(pack_model(10'h003)), 32'h79);
        check("t3_model_data", 32'(exp_q[0].data), 32'h79797A);
        run_load("t3", 12'h030, 1, 1'b0, 1'b0);

        // Address wrap at the top of the SRAM.
        beats = '{10'h155, 10'h2AA, 10'h000, 10'h001, 10'h155, 10'h2AA};
        lasts = '{0, 0, 0, 0, 0, 1};
        build_model(12'hFFF, 2, 1'b1);
        check("t4_model_wrap", 32'(exp_q[1].addr), 32'h000);
        run_load("t4", 12'hFFF, 2, 1'b1, 1'b0);

        // Count reached without tlast: the extra beat stays unaccepted.
        beats = '{10'h000, 10'h000, 10'h000, 10'h000};
        lasts = '{0, 0, 0, 0};
        build_model(12'h040, 1, 1'b0);
        check("t5_model_acc", 32'(exp_acc), 32'd3);
        run_load("t5", 12'h040, 1, 1'b0, 1'b0);

        // Empty load.
        beats = '{10'h155};
        lasts = '{1};
        build_model(12'h050, 0, 1'b0);
        run_load("t5b", 12'h050, 0, 1'b0, 1'b0);

        // Reset in the middle of a word, then a clean load elsewhere.
        @(negedge clk);
        cfg_base_addr  = 12'h100;
        cfg_word_count = 13'd2;
        cfg_bank       = 1'b0;
        cfg_start      = 1'b1;
        @(negedge clk);
        cfg_start     = 1'b0;
        s_if.s_tvalid = 1'b1;
        s_if.s_tdata  = 10'h155;
        repeat (2) @(negedge clk);
        s_if.s_tvalid = 1'b0;
        reset_n       = 1'b0;
        @(negedge clk);
        check_idle_zero("t6_reset");
        reset_n = 1'b1;
        beats = '{10'h2AA, 10'h2AA, 10'h2AA};
        lasts = '{0, 0, 1};
        build_model(12'h200, 1, 1'b1);
        check("t6_model_addr", 32'(exp_q[0].addr), 32'h200);
        run_load("t6", 12'h200, 1, 1'b1, 1'b0);

        // Same multi-word stream with and without valid gaps must give the same writes.
        beats.delete();
        lasts.delete();
        for (int i = 0; i < 12; i++) begin
            beats.push_back(10'((i * 37 + 5) % 1024));
            lasts.push_back(i == 11);
        end
        build_model(12'h300, 4, 1'b0);
        run_load("t7_gaps", 12'h300, 4, 1'b0, 1'b1);
        build_model(12'h300, 4, 1'b0);
        run_load("t7_flat", 12'h300, 4, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
